// File: rtl/sap1_program_memory_if.sv
// SAP-1 program memory bus bundle.
// Groups the loader handshake, run-mode read request and the shared W-bus
// output of the program memory. CLK/CLR stay as plain ports on the memory.
//   PROG        1 = program mode, 0 = run mode
//   load_data   word offered to the loader
//   load_valid  load_data is valid
//   load_ready  loader accepts a word this cycle
//   load_done   every word of the array written in the current load session
//   load_count  words accepted in the current load session
//   address_in  run-mode read address (from the memory address register)
//   CEbar       active-low chip enable for run-mode reads
//   data_out    tri-state W-bus output, Z when not driving
//   data_valid  data_out is being driven
interface sap1_program_memory_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  PROG;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_ready;
  logic                  load_done;
  logic [ADDR_WIDTH:0]   load_count;
  logic [ADDR_WIDTH-1:0] address_in;
  logic                  CEbar;
  wire  [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;

  modport master (
    output PROG, load_data, load_valid, address_in, CEbar,
    input  load_ready, load_done, load_count, data_out, data_valid
  );

  modport slave (
    input  PROG, load_data, load_valid, address_in, CEbar,
    output load_ready, load_done, load_count, data_out, data_valid
  );
endinterface

// File: rtl/sap1_program_memory.sv
// SAP-1 program memory: DEPTH x DATA_WIDTH words, loadable in program mode,
// read onto the shared W bus in run mode.
// Ports:
//   CLK  system clock, rising edge
//   CLR  asynchronous active-high reset (memory array is not cleared)
//   bus  sap1_program_memory_if.slave (loader handshake, read request, W bus)
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal operation, CEbar-gated registered reads onto the bus
// LOAD  | program mode, accepting words into consecutive addresses
// FULL  | program mode, every address written; further words ignored
module sap1_program_memory #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                  CLK,
  input logic                  CLR,
  sap1_program_memory_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   load_count;
  logic [DATA_WIDTH-1:0] out_reg;
  logic                  rd_q;
  logic                  accept;
  logic                  last_word;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign bus.load_ready = (state == LOAD) && bus.PROG;
  assign accept         = bus.load_ready && bus.load_valid;
  assign last_word      = (ptr == ADDR_WIDTH'(DEPTH - 1));
  // A read is only launched when the memory stays in RUN across the edge, so
  // the bus is already released on the first LOAD cycle.
  assign rd_en          = (state == RUN) && !bus.PROG && !bus.CEbar;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:  if (bus.PROG) state_next = LOAD;
      LOAD: begin
        if (!bus.PROG)                  state_next = RUN;
        else if (accept && last_word)   state_next = FULL;
      end
      FULL: if (!bus.PROG) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ptr        <= '0;
      load_count <= '0;
    end else if (state_next != state && state_next != FULL) begin
      // Entering a fresh load session or returning to run: restart counting.
      ptr        <= '0;
      load_count <= '0;
    end else if (accept) begin
      if (!last_word) ptr <= ptr + ADDR_WIDTH'(1);
      load_count <= load_count + (ADDR_WIDTH + 1)'(1);
    end
  end

  // No reset on the array; accept is impossible while CLR holds state in RUN.
  always_ff @(posedge CLK) begin
    if (accept) mem[ptr] <= bus.load_data;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      out_reg <= '0;
      rd_q    <= 1'b0;
    end else begin
      rd_q <= rd_en;
      if (rd_en) out_reg <= mem[bus.address_in];
    end
  end

  assign bus.data_out   = rd_q ? out_reg : {DATA_WIDTH{1'bz}};
  assign bus.data_valid = rd_q;
  assign bus.load_done  = (state == FULL);
  assign bus.load_count = load_count;
endmodule
